// File: rtl/fifo_rd_drain.sv
`default_nettype none
// ============================================================================
// Module      : fifo_rd_drain
// Description : Read-side drain engine for a FIFO. Issues read strobes while
//               the FIFO is non-empty and there is room downstream, absorbs
//               the FIFO's one-cycle registered read latency, and presents the
//               words on a valid/ready stream through a small circular output
//               buffer. Also provides a synchronous flush and a count of
//               words delivered downstream.
//
// Ports       : clk_rd        read-domain clock, rising edge
//               rst           synchronous reset, active-high
//               fifo_empty    FIFO empty flag (clk_rd domain)
//               fifo_r_valid  read strobe to FIFO (combinational)
//               fifo_r_data   FIFO read data, valid the cycle after a strobe
//               m_valid       stream word available
//               m_ready       downstream ready
//               m_data        stream word (head of output buffer)
//               flush         synchronous discard of buffered/in-flight words
//               busy          buffer non-empty or a read in flight
//               words_out     words accepted downstream (wraps)
//
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_rd_drain #(
    parameter int DATA_WIDTH = 8,
    parameter int OUT_DEPTH  = 2,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk_rd,
    input  logic                  rst,
    input  logic                  fifo_empty,
    output logic                  fifo_r_valid,
    input  logic [DATA_WIDTH-1:0] fifo_r_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  flush,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  words_out
);

    // Pointer width covers indices 0..OUT_DEPTH-1; the occupancy width has
    // one spare bit so count + inflight never overflows before the compare.
    localparam int c_PTR_W = $clog2(OUT_DEPTH);
    localparam int c_OCC_W = $clog2(OUT_DEPTH + 1) + 1;

    localparam logic [c_OCC_W-1:0] c_DEPTH    = c_OCC_W'(OUT_DEPTH);
    localparam logic [c_PTR_W-1:0] c_LAST_PTR = c_PTR_W'(OUT_DEPTH - 1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] r_mem [OUT_DEPTH];
    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic [c_OCC_W-1:0]    r_count;
    logic                  r_inflight;
    logic                  r_discard;
    logic [CNT_WIDTH-1:0]  r_words_out;

    logic                  w_pop;
    logic                  w_accept;
    logic                  w_write;
    logic [c_OCC_W-1:0]    w_occ;

    // Pointers wrap explicitly so non-power-of-two depths (3) work.
    function automatic logic [c_PTR_W-1:0] f_next_ptr(input logic [c_PTR_W-1:0] p);
        return (p == c_LAST_PTR) ? '0 : p + c_PTR_W'(1);
    endfunction

    // ------------------------------------------------------------------------
    // Read issue
    // ------------------------------------------------------------------------
    assign w_pop = m_valid && m_ready;

    // Occupancy after this edge if no new read were issued: buffered words
    // plus the word returning this cycle, minus the word leaving downstream.
    // Issuing only while this is below OUT_DEPTH guarantees that every word
    // in flight has a buffer slot by the time it lands.
    assign w_occ = r_count + c_OCC_W'(r_inflight) - c_OCC_W'(w_pop);

    assign fifo_r_valid = !rst && !flush && !fifo_empty && (w_occ < c_DEPTH);
    assign w_accept     = fifo_r_valid && !fifo_empty;

    // The returning word is stored unless it belongs to a flushed request.
    assign w_write = r_inflight && !r_discard;

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign m_valid   = (r_count != '0);
    assign m_data    = r_mem[r_rd_ptr];
    assign busy      = (r_count != '0) || r_inflight;
    assign words_out = r_words_out;

    // ------------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_rd) begin
        if (rst) begin
            for (int i = 0; i < OUT_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_inflight  <= 1'b0;
            r_discard   <= 1'b0;
            r_words_out <= '0;
        end else if (flush) begin
            // Buffer is emptied; a word returning this very cycle is simply
            // not written. No read is issued during flush, so nothing new is
            // in flight afterwards. No pop is counted.
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_inflight <= w_accept;
            r_discard  <= r_inflight;
        end else begin
            r_inflight <= w_accept;
            // The flushed word returned during the flush cycle, so the
            // discard marker only has to cover the cycle that follows it.
            r_discard  <= 1'b0;

            if (w_write) begin
                r_mem[r_wr_ptr] <= fifo_r_data;
                r_wr_ptr        <= f_next_ptr(r_wr_ptr);
            end

            if (w_pop) begin
                r_rd_ptr    <= f_next_ptr(r_rd_ptr);
                r_words_out <= r_words_out + CNT_WIDTH'(1);
            end

            // Simultaneous write and pop leaves the count unchanged.
            case ({w_write, w_pop})
                2'b10:   r_count <= r_count + c_OCC_W'(1);
                2'b01:   r_count <= r_count - c_OCC_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire
